hc_csr_bank: RTL and testbench

- Parametrised HardCloud CSR block: decodes CCI-P MMIO writes and reads for DSM base, control and NUM_BUFFERS buffer descriptors.
- Adds MMIO read-back, a run-control state machine and a status register.
- Sits between the CCI-P MMIO channel (c0 Rx / c2 Tx) and the accelerator datapath (read/write engines).

---
 rtl/hc_csr_bank.sv | 133 +++++++++++++
 tb/tb_hc_csr_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hc_csr_bank.sv
// hc_csr_bank: CCI-P MMIO CSR bank with buffer descriptors, run-control FSM and status read-back
// Ports: clk, reset (async, active-high); mmio_wr_valid/mmio_rd_valid/mmio_addr (dword)/mmio_tid/mmio_wdata
// from c0; mmio_rsp_valid/mmio_rsp_tid/mmio_rsp_data to c2; dsm_base, buf_addr, buf_size, buf_valid
// to the datapath; acc_rst/acc_start/running out and acc_done in for run control.
// Optional: define HC_CSR_CYCLE_CNT_EN for the 64-bit CYCLES run counter at CSR_BASE+8.
module hc_csr_bank #(
  parameter int          NUM_BUFFERS = 3,
  parameter logic [15:0] CSR_BASE    = 16'h0F0,
  parameter int          SIZE_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mmio_wr_valid,
  input  logic                          mmio_rd_valid,
  input  logic [15:0]                   mmio_addr,
  input  logic [8:0]                    mmio_tid,
  input  logic [63:0]                   mmio_wdata,
  output logic                          mmio_rsp_valid,
  output logic [8:0]                    mmio_rsp_tid,
  output logic [63:0]                   mmio_rsp_data,
  output logic [63:0]                   dsm_base,
  output logic [64*NUM_BUFFERS-1:0]     buf_addr,
  output logic [SIZE_W*NUM_BUFFERS-1:0] buf_size,
  output logic [NUM_BUFFERS-1:0]        buf_valid,
  output logic                          acc_rst,
  output logic                          acc_start,
  input  logic                          acc_done,
  output logic                          running
);
  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;
  localparam logic [15:0] ST_A = CSR_BASE >> 2;
  localparam logic [15:0] CY_A = (CSR_BASE + 16'd8) >> 2;
  localparam logic [13:0] NB   = 14'(NUM_BUFFERS);
  state_t      state, nxt;
  logic        err, set_err, hit, bhit, wr_ok, ctrl_wr, all_valid;
  logic [13:0] bidx;
  logic [31:0] cmd, ctrl;
  logic [63:0] status, cycles, rdata;
  // Dword < 0x100 is byte < 0x400; 64-bit registers sit on even dwords only.
  assign hit       = mmio_addr[15:8] == 8'd0 && !mmio_addr[0];
  assign bidx      = 14'((mmio_addr - 16'h48) >> 2);
  assign bhit      = hit && mmio_addr >= 16'h48 && bidx < NB;
  assign wr_ok     = mmio_wr_valid && state != S_RUN;
  assign ctrl_wr   = mmio_wr_valid && mmio_addr == 16'h46;
  assign cmd       = mmio_wdata[31:0];
  assign all_valid = &buf_valid;
  assign acc_rst   = state == S_RESET;
  assign running   = state == S_RUN;
  assign status    = {48'd0, 8'(buf_valid), 4'd0, err, 3'(state)};
  for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_buf
    logic              sel, v;
    logic [63:0]       a;
    logic [SIZE_W-1:0] s;
    assign sel = wr_ok && bhit && bidx == 14'(i);
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        a <= '0;
        s <= '0;
        v <= 1'b0;
      end else begin
        if (sel && !mmio_addr[1]) a <= mmio_wdata;
        if (sel && mmio_addr[1]) s <= mmio_wdata[SIZE_W-1:0];
        v <= (nxt == S_RESET) ? 1'b0 : v | (sel && mmio_addr[1]);
      end
    assign buf_addr[64*i+:64]         = a;
    assign buf_size[SIZE_W*i+:SIZE_W] = s;
    assign buf_valid[i]               = v;
  end
  always_comb begin
    nxt     = state;
    set_err = 1'b0;
    case (state)
      S_RESET: nxt = (ctrl_wr && cmd == 32'h1) ? S_IDLE : S_RESET;
      // A STOP write in the same cycle as acc_done takes priority.
      S_RUN:   nxt = (ctrl_wr && cmd == 32'h7) ? S_STOP : acc_done ? S_DONE : S_RUN;
      default: begin
        if (ctrl_wr && cmd == 32'h3) begin
          nxt     = all_valid ? S_RUN : state;
          set_err = !all_valid;
        end else if (ctrl_wr && cmd == 32'h1) nxt = S_IDLE;
      end
    endcase
    if (ctrl_wr && cmd == 32'h0) nxt = S_RESET;
  end
  always_comb begin
    rdata = 64'd0;
    if (hit) begin
      rdata = mmio_addr == 16'h44 ? dsm_base :
              mmio_addr == 16'h46 ? {32'd0, ctrl} :
              mmio_addr == ST_A   ? status :
              mmio_addr == CY_A   ? cycles : 64'd0;
      for (int i = 0; i < NUM_BUFFERS; i++)
        if (bhit && bidx == 14'(i))
          rdata = mmio_addr[1] ? 64'(buf_size[SIZE_W*i+:SIZE_W]) : buf_addr[64*i+:64];
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state          <= S_RESET;
      err            <= 1'b0;
      ctrl           <= 32'd0;
      acc_start      <= 1'b0;
      dsm_base       <= 64'd0;
      mmio_rsp_valid <= 1'b0;
      mmio_rsp_tid   <= 9'd0;
      mmio_rsp_data  <= 64'd0;
    end else begin
      state          <= nxt;
      err            <= (nxt == S_RESET) ? 1'b0 : err | set_err;
      acc_start      <= nxt == S_RUN && state != S_RUN;
      mmio_rsp_valid <= mmio_rd_valid;
      if (ctrl_wr) ctrl <= cmd;
      if (wr_ok && mmio_addr == 16'h44) dsm_base <= mmio_wdata;
      if (mmio_rd_valid) begin
        mmio_rsp_tid  <= mmio_tid;
        mmio_rsp_data <= rdata;
      end
    end
`ifdef HC_CSR_CYCLE_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) cycles <= 64'd0;
    else if (nxt == S_RUN && state != S_RUN) cycles <= 64'd0;
    else if (state == S_RUN) cycles <= cycles + 64'd1;
`else
  assign cycles = 64'd0;
`endif
endmodule

// File: tb/tb_hc_csr_bank.sv
// tb_hc_csr_bank: randomized self-checking bench for hc_csr_bank against a byte-address reference model
module tb_hc_csr_bank;
  localparam int NB = 3;
  localparam int SW = 32;
  localparam int CSR_BASE = 'h0F0;
  localparam int RST = 0, IDLE = 1, RUN = 2, STOP = 3, DONE = 4;
  logic            clk = 1'b0;
  logic            reset;
  logic            mmio_wr_valid, mmio_rd_valid, acc_done;
  logic [15:0]     mmio_addr;
  logic [8:0]      mmio_tid;
  logic [63:0]     mmio_wdata;
  logic            mmio_rsp_valid;
  logic [8:0]      mmio_rsp_tid;
  logic [63:0]     mmio_rsp_data, dsm_base;
  logic [64*NB-1:0] buf_addr;
  logic [SW*NB-1:0] buf_size;
  logic [NB-1:0]   buf_valid;
  logic            acc_rst, acc_start, running;
  int              n_chk = 0, n_err = 0;
  int              ms;
  logic [63:0]     m_addr [NB];
  logic [SW-1:0]   m_size [NB];
  logic            m_valid [NB];
  logic [63:0]     m_dsm, m_cyc, e_data;
  logic [31:0]     m_ctrl;
  logic            m_err, e_rv, e_start;
  logic [8:0]      e_tid;
  hc_csr_bank dut (
    .clk(clk), .reset(reset),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .mmio_rsp_valid(mmio_rsp_valid), .mmio_rsp_tid(mmio_rsp_tid), .mmio_rsp_data(mmio_rsp_data),
    .dsm_base(dsm_base), .buf_addr(buf_addr), .buf_size(buf_size), .buf_valid(buf_valid),
    .acc_rst(acc_rst), .acc_start(acc_start), .acc_done(acc_done), .running(running)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic mreset();
    ms = RST; m_dsm = 0; m_cyc = 0; m_ctrl = 0; m_err = 0;
    e_rv = 0; e_start = 0; e_tid = 0; e_data = 0;
    for (int i = 0; i < NB; i++) begin
      m_addr[i] = 0; m_size[i] = 0; m_valid[i] = 0;
    end
  endtask
  function automatic logic [63:0] mread(input logic [15:0] a);
    int b, o;
    logic [63:0] vm;
    b = int'(a) * 4;
    o = b - 'h120;
    vm = 0;
    for (int i = 0; i < NB; i++) if (m_valid[i]) vm += 64'(1) << i;
    if (b >= 'h400) return 0;
    if (b == 'h110) return m_dsm;
    if (b == 'h118) return {32'd0, m_ctrl};
    if (b == CSR_BASE) return 64'(ms) + (m_err ? 64'd8 : 64'd0) + (vm << 8);
`ifdef HC_CSR_CYCLE_CNT_EN
    if (b == CSR_BASE + 8) return m_cyc;
`else
    if (b == CSR_BASE + 8) return 0;
`endif
    if (o >= 0 && o % 8 == 0 && o / 16 < NB) return (o % 16 == 8) ? 64'(m_size[o/16]) : m_addr[o/16];
    return 0;
  endfunction
  task automatic cyc(input logic w, input logic r, input logic [15:0] a, input logic [8:0] t,
                     input logic [63:0] d, input logic dn);
    int b, o, ns;
    logic allv;
    logic [64*NB-1:0] ea;
    logic [SW*NB-1:0] es;
    logic [NB-1:0] ev;
    mmio_wr_valid = w; mmio_rd_valid = r; mmio_addr = a; mmio_tid = t; mmio_wdata = d; acc_done = dn;
    e_rv = r;
    if (r) begin
      e_tid = t;
      e_data = mread(a);
    end
    b = int'(a) * 4;
    o = b - 'h120;
    allv = 1;
    for (int i = 0; i < NB; i++) allv &= m_valid[i];
    if (w && ms != RUN && b < 'h400) begin
      if (b == 'h110) m_dsm = d;
      else if (o >= 0 && o % 8 == 0 && o / 16 < NB) begin
        if (o % 16 == 8) begin
          m_size[o/16] = d[SW-1:0];
          m_valid[o/16] = 1;
        end else m_addr[o/16] = d;
      end
    end
    ns = ms;
    if (w && b == 'h118) begin
      m_ctrl = d[31:0];
      if (d[31:0] == 0) ns = RST;
      else if (d[31:0] == 1 && ms != RUN) ns = IDLE;
      else if (d[31:0] == 3 && ms != RST && ms != RUN) begin
        if (allv) ns = RUN;
        else m_err = 1;
      end else if (d[31:0] == 7 && ms == RUN) ns = STOP;
    end
    if (ms == RUN && ns == RUN && dn) ns = DONE;
    if (ns == RST) begin
      m_err = 0;
      for (int i = 0; i < NB; i++) m_valid[i] = 0;
    end
    e_start = ns == RUN && ms != RUN;
    m_cyc = e_start ? 64'd0 : (ms == RUN) ? m_cyc + 64'd1 : m_cyc;
    ms = ns;
    for (int i = 0; i < NB; i++) begin
      ea[64*i+:64] = m_addr[i];
      es[SW*i+:SW] = m_size[i];
      ev[i] = m_valid[i];
    end
    @(posedge clk);
    #1;
    check("rsp_valid", mmio_rsp_valid, e_rv);
    check("rsp_tid", mmio_rsp_tid, e_tid);
    check("rsp_data", mmio_rsp_data, e_data);
    check("acc_start", acc_start, e_start);
    check("running", running, ms == RUN);
    check("acc_rst", acc_rst, ms == RST);
    check("buf_valid", buf_valid, ev);
    check("dsm_base", dsm_base, m_dsm);
    check("buf_addr", buf_addr, ea);
    check("buf_size", buf_size, es);
  endtask
  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    cyc(1'b1, 1'b0, a, 9'd0, d, 1'b0);
  endtask
  task automatic rd(input logic [15:0] a, input logic [8:0] t);
    cyc(1'b0, 1'b1, a, t, 64'd0, 1'b0);
  endtask
  function automatic logic [15:0] raddr();
    case ($urandom_range(0, 9))
      0: return 16'h44;
      1, 2: return 16'h46;
      3: return $urandom_range(0, 1) ? 16'h3C : 16'h3E;
      4, 5, 6: return 16'(16'h48 + 16'($urandom_range(0, 3)) * 16'd4 + ($urandom_range(0, 1) ? 16'd2 : 16'd0));
      7: return 16'h58;
      8: return 16'($urandom_range(0, 'h1FF));
      default: return 16'($urandom);
    endcase
  endfunction
  function automatic logic [63:0] rcmd();
    case ($urandom_range(0, 9))
      0: return 64'd0;
      1, 2, 3: return 64'd1;
      4, 5, 6: return 64'd3;
      7, 8: return 64'd7;
      default: return {$urandom, $urandom};
    endcase
  endfunction
  initial begin
    reset = 1'b1;
    mmio_wr_valid = 0; mmio_rd_valid = 0; mmio_addr = 0; mmio_tid = 0; mmio_wdata = 0; acc_done = 0;
    mreset();
    #1;
    check("rst_acc_rst", acc_rst, 1'b1);
    check("rst_running", running, 1'b0);
    check("rst_start", acc_start, 1'b0);
    check("rst_rsp_valid", mmio_rsp_valid, 1'b0);
    check("rst_buf_valid", buf_valid, 0);
    check("rst_dsm", dsm_base, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rd(16'h3C, 9'h05);
    check("status_reset", mmio_rsp_data, 64'h0);
    check("status_tid", mmio_rsp_tid, 9'h05);
    wr(16'h46, 64'h1);
    wr(16'h44, 64'hDEAD_BEEF_0000_1100);
    for (int i = 0; i < NB; i++) begin
      wr(16'(16'h48 + 4 * i), 64'h1000_0000 + 64'(i) * 64'h100);
      wr(16'(16'h4A + 4 * i), 64'h40);
    end
    wr(16'h46, 64'h3);
    check("start_pulse", acc_start, 1'b1);
    rd(16'h3C, 9'h11);
    check("start_once", acc_start, 1'b0);
    check("status_run", mmio_rsp_data, 64'h0702);
    check("buf0_addr", buf_addr[63:0], 64'h1000_0000);
    wr(16'h4E, 64'h99);
    check("run_size_hold", buf_size[2*SW-1:SW], 32'h40);
    cyc(1'b0, 1'b0, 16'h0, 9'd0, 64'd0, 1'b1);
    rd(16'h3C, 9'h12);
    check("status_done", mmio_rsp_data[2:0], 3'd4);
    wr(16'h46, 64'h0);
    wr(16'h46, 64'h1);
    wr(16'h4A, 64'h80);
    wr(16'h46, 64'h3);
    check("no_start", acc_start, 1'b0);
    rd(16'h3C, 9'h13);
    check("status_err", mmio_rsp_data, 64'h0109);
    wr(16'h4E, 64'h80);
    wr(16'h52, 64'h80);
    wr(16'h46, 64'h3);
    repeat (99) cyc(1'b0, 1'b0, 16'h0, 9'd0, 64'd0, 1'b0);
    wr(16'h46, 64'h7);
    rd(16'h3E, 9'h14);
`ifdef HC_CSR_CYCLE_CNT_EN
    check("cycles_100", mmio_rsp_data, 64'd100);
`else
    check("cycles_zero", mmio_rsp_data, 64'd0);
`endif
    wr(16'h46, 64'h3);
    check("rerun_running", running, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_acc_rst", acc_rst, 1'b1);
    check("async_running", running, 1'b0);
    check("async_buf_valid", buf_valid, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    mreset();
    wr(16'h46, 64'h1);
    wr(16'h58, 64'h1234_5678);
    wr(16'h5A, 64'h55);
    check("oob_addr", buf_addr, 0);
    check("oob_valid", buf_valid, 0);
    for (int k = 0; k < 2000; k++) begin
      logic [15:0] a;
      logic [63:0] d;
      a = raddr();
      d = (a == 16'h46) ? rcmd() : {$urandom, $urandom};
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, 9'($urandom), d, $urandom_range(0, 7) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
